// File: rtl/escalonador_display_pkg.sv
// Shared definitions for the display scheduler: image-source codes, state
// width, default death image, FSM encoding and the frame-advance helper.
package escalonador_display_pkg;

  localparam int unsigned ESTADO_W = 4;

  localparam logic FONTE_IMAGEM = 1'b0;
  localparam logic FONTE_ATRIB  = 1'b1;

  localparam logic [ESTADO_W-1:0] IMG_MORTE_PADRAO = 4'hF;

  typedef enum logic {
    OCIOSO   = 1'b0,
    ENVIANDO = 1'b1
  } estado_fsm_e;

  // Next animation frame, wrapping at n_quadros rather than at 16.
  function automatic logic [3:0] proximo_quadro(input logic [3:0] atual,
                                                input int unsigned n_quadros);
    if (n_quadros <= 1 || {28'b0, atual} >= n_quadros - 1) begin
      return '0;
    end
    return atual + 4'd1;
  endfunction

endpackage

// File: rtl/escalonador_display_if.sv
// Scheduler <-> display driver bundle.
//   disp_pronto : driver idle and ready (level, from driver)
//   disp_fim    : driver finished the frame (pulse, from driver)
//   disp_inicio : start a frame transfer (pulse, to driver)
//   sel_fonte   : 0 = pet image, 1 = attribute bar
//   sel_imagem  : image index for the current transfer
//   quadro      : animation frame index for the current transfer
// master = scheduler side, slave = driver side.
interface escalonador_display_if;

  logic                                     disp_pronto;
  logic                                     disp_fim;
  logic                                     disp_inicio;
  logic                                     sel_fonte;
  logic [escalonador_display_pkg::ESTADO_W-1:0] sel_imagem;
  logic [3:0]                               quadro;

  modport master (
    input  disp_pronto, disp_fim,
    output disp_inicio, sel_fonte, sel_imagem, quadro
  );

  modport slave (
    output disp_pronto, disp_fim,
    input  disp_inicio, sel_fonte, sel_imagem, quadro
  );

endinterface

// File: rtl/escalonador_display_gerador_tick.sv
// Free-running counter 0..TICK_CICLOS-1 with a one-cycle pulse on the wrap
// cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : high during the cycle the counter holds TICK_CICLOS-1
module gerador_tick #(
  parameter int unsigned TICK_CICLOS = 2700000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_CICLOS > 1) ? $clog2(TICK_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/escalonador_display.sv
// Display transfer scheduler. Collects state-change, attribute-change and
// animation-tick refresh requests, grants them in fixed priority
// (estado > atrib > anim), and runs the driver through a start/done
// handshake with a timeout.
//   clk, rst_n   : clock, asynchronous active-low reset
//   estado       : current pet state
//   morreu       : death flag (level)
//   atrib_mudou  : attribute changed (pulse)
//   disp         : driver handshake and image selection (master side)
//   ocupado      : transfer outstanding
//   erro_timeout : sticky, a transfer exceeded TIMEOUT_CICLOS
module escalonador_display
  import escalonador_display_pkg::*;
#(
  parameter int unsigned           TICK_CICLOS    = 2700000,
  parameter int unsigned           ANIM_QUADROS   = 2,
  parameter int unsigned           TIMEOUT_CICLOS = 4000000,
  parameter logic [ESTADO_W-1:0]   IMG_MORTE      = IMG_MORTE_PADRAO
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ESTADO_W-1:0]   estado,
  input  logic                  morreu,
  input  logic                  atrib_mudou,
  escalonador_display_if.master disp,
  output logic                  ocupado,
  output logic                  erro_timeout
);

  localparam int unsigned TO_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CICLOS - 1);

  estado_fsm_e         fsm_q, fsm_d;
  logic [ESTADO_W-1:0] estado_ant_q, estado_ant_d;
  logic                morto_q, morto_d;
  logic                pend_estado_q, pend_estado_d;
  logic                pend_atrib_q, pend_atrib_d;
  logic                pend_anim_q, pend_anim_d;
  logic                disp_inicio_q, disp_inicio_d;
  logic                sel_fonte_q, sel_fonte_d;
  logic [ESTADO_W-1:0] sel_imagem_q, sel_imagem_d;
  logic [3:0]          quadro_q, quadro_d;
  logic                erro_q, erro_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

  logic tick;
  logic set_estado, set_anim;
  logic clr_estado, clr_atrib, clr_anim;

  gerador_tick #(.TICK_CICLOS(TICK_CICLOS)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    fsm_d         = fsm_q;
    sel_fonte_d   = sel_fonte_q;
    sel_imagem_d  = sel_imagem_q;
    quadro_d      = quadro_q;
    erro_d        = erro_q;
    to_cnt_d      = to_cnt_q;
    disp_inicio_d = 1'b0;
    clr_estado    = 1'b0;
    clr_atrib     = 1'b0;
    clr_anim      = 1'b0;

    // Request capture runs every cycle, independent of the FSM.
    estado_ant_d = estado;
    morto_d      = morto_q | morreu;
    set_estado   = (estado != estado_ant_q) || (!morto_q && morreu);
    set_anim     = tick && !morto_q && (ANIM_QUADROS > 1);

    unique case (fsm_q)
      OCIOSO: begin
        if (disp.disp_pronto && (pend_estado_q || pend_atrib_q || pend_anim_q)) begin
          fsm_d         = ENVIANDO;
          disp_inicio_d = 1'b1;
          to_cnt_d      = '0;
          if (pend_estado_q) begin
            sel_fonte_d  = FONTE_IMAGEM;
            sel_imagem_d = morto_q ? IMG_MORTE : estado;
            quadro_d     = '0;
            clr_estado   = 1'b1;
            // A fresh image supersedes any pending animation step.
            clr_anim     = 1'b1;
          end else if (pend_atrib_q) begin
            sel_fonte_d = FONTE_ATRIB;
            clr_atrib   = 1'b1;
          end else begin
            sel_fonte_d = FONTE_IMAGEM;
            quadro_d    = proximo_quadro(quadro_q, ANIM_QUADROS);
            clr_anim    = 1'b1;
          end
        end
      end
      ENVIANDO: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // Completion takes precedence over a timeout in the same cycle.
        if (disp.disp_fim) begin
          fsm_d = OCIOSO;
        end else if (to_cnt_q == TO_MAX) begin
          fsm_d  = OCIOSO;
          erro_d = 1'b1;
        end
      end
      default: fsm_d = OCIOSO;
    endcase

    // New requests win over a grant clearing the same flag.
    pend_estado_d = (pend_estado_q & ~clr_estado) | set_estado;
    pend_atrib_d  = (pend_atrib_q  & ~clr_atrib)  | atrib_mudou;
    pend_anim_d   = (pend_anim_q   & ~clr_anim)   | set_anim;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= OCIOSO;
      estado_ant_q  <= '0;
      morto_q       <= 1'b0;
      pend_estado_q <= 1'b1;
      pend_atrib_q  <= 1'b0;
      pend_anim_q   <= 1'b0;
      disp_inicio_q <= 1'b0;
      sel_fonte_q   <= FONTE_IMAGEM;
      sel_imagem_q  <= '0;
      quadro_q      <= '0;
      erro_q        <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      fsm_q         <= fsm_d;
      estado_ant_q  <= estado_ant_d;
      morto_q       <= morto_d;
      pend_estado_q <= pend_estado_d;
      pend_atrib_q  <= pend_atrib_d;
      pend_anim_q   <= pend_anim_d;
      disp_inicio_q <= disp_inicio_d;
      sel_fonte_q   <= sel_fonte_d;
      sel_imagem_q  <= sel_imagem_d;
      quadro_q      <= quadro_d;
      erro_q        <= erro_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign disp.disp_inicio = disp_inicio_q;
  assign disp.sel_fonte   = sel_fonte_q;
  assign disp.sel_imagem  = sel_imagem_q;
  assign disp.quadro      = quadro_q;
  assign ocupado          = (fsm_q == ENVIANDO);
  assign erro_timeout     = erro_q;

endmodule
